// File: rtl/present_object_controller_if.sv
// Pixel-scan, spawn and collision bundle for one bonus present.
// slave is the controller side, master is the driver side.
interface present_object_controller_if;
    logic        startOfFrame;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        spawn;
    logic [10:0] spawnX;
    logic        col_player_present;
    logic        col_rope_present;
    logic        presentRequest;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic        collected;
    logic        active;

    modport slave (
        input  startOfFrame, pixelX, pixelY, spawn, spawnX,
        input  col_player_present, col_rope_present,
        output presentRequest, topLeftX, topLeftY, collected, active
    );

    modport master (
        output startOfFrame, pixelX, pixelY, spawn, spawnX,
        output col_player_present, col_rope_present,
        input  presentRequest, topLeftX, topLeftY, collected, active
    );
endinterface

// File: rtl/present_object_controller.sv
// One bonus present: spawn, hang, fall, land, expire or collect.
// Collision strobes are latched per frame and consumed at startOfFrame.
module present_object_controller #(
    parameter int SIZE         = 32,
    parameter int START_Y      = 32,
    parameter int FLOOR_Y      = 448,
    parameter int FALL_SPEED   = 2,
    parameter int LIFETIME     = 300,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                        clk,
    input  logic                        resetN,
    present_object_controller_if.slave  bus
);
    localparam logic [11:0] SZ      = 12'(SIZE);
    localparam logic [10:0] MAX_X   = 11'(640 - SIZE);
    localparam logic [10:0] START   = 11'(START_Y);
    localparam logic [11:0] LAND_Y  = 12'(FLOOR_Y - SIZE);
    localparam logic [11:0] FALL    = 12'(FALL_SPEED);
    localparam logic [8:0]  LIFE_LAST   = 9'(LIFETIME - 1);
    localparam logic [8:0]  BLINK_START = 9'(LIFETIME - BLINK_FRAMES);

    typedef enum logic [1:0] {IDLE, HANGING, FALLING, LANDED} state_e;

    state_e      state_q, state_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic [8:0]  life_q, life_d;
    logic        hit_p_q, hit_p_d;
    logic        hit_r_q, hit_r_d;
    logic        pend_q, pend_d;
    logic        coll_q, coll_d;
    logic [11:0] fall_sum;
    logic        visible;
    logic        in_x, in_y;

    assign fall_sum = {1'b0, y_q} + FALL;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            life_q  <= '0;
            hit_p_q <= 1'b0;
            hit_r_q <= 1'b0;
            pend_q  <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            life_q  <= life_d;
            hit_p_q <= hit_p_d;
            hit_r_q <= hit_r_d;
            pend_q  <= pend_d;
            coll_q  <= coll_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        life_d  = life_q;
        coll_d  = 1'b0;
        hit_p_d = hit_p_q | bus.col_player_present;
        hit_r_d = hit_r_q | bus.col_rope_present;
        pend_d  = pend_q | (bus.spawn && state_q == IDLE);
        if (bus.startOfFrame) begin
            // Strobes arriving with the frame pulse carry over to the next frame
            hit_p_d = bus.col_player_present;
            hit_r_d = bus.col_rope_present;
            pend_d  = bus.spawn && state_q == IDLE;
            unique case (state_q)
                IDLE: begin
                    if (pend_q) begin
                        state_d = HANGING;
                        x_d     = (bus.spawnX > MAX_X) ? MAX_X : bus.spawnX;
                        y_d     = START;
                    end
                end
                HANGING: begin
                    if (hit_p_q) begin
                        state_d = IDLE;
                        coll_d  = 1'b1;
                    end else if (hit_r_q) begin
                        state_d = FALLING;
                    end
                end
                FALLING: begin
                    if (hit_p_q) begin
                        state_d = IDLE;
                        coll_d  = 1'b1;
                    end else if (fall_sum >= LAND_Y) begin
                        state_d = LANDED;
                        y_d     = LAND_Y[10:0];
                        life_d  = '0;
                    end else begin
                        y_d = fall_sum[10:0];
                    end
                end
                LANDED: begin
                    if (hit_p_q) begin
                        state_d = IDLE;
                        coll_d  = 1'b1;
                    end else if (life_q == LIFE_LAST) begin
                        state_d = IDLE;
                    end else begin
                        life_d = life_q + 9'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        visible = 1'b0;
        unique case (state_q)
            HANGING, FALLING: visible = 1'b1;
            LANDED:  visible = (life_q < BLINK_START) || !life_q[3];
            default: visible = 1'b0;
        endcase
    end

    assign in_x = ({1'b0, bus.pixelX} >= {1'b0, x_q})
               && ({1'b0, bus.pixelX} < ({1'b0, x_q} + SZ));
    assign in_y = ({1'b0, bus.pixelY} >= {1'b0, y_q})
               && ({1'b0, bus.pixelY} < ({1'b0, y_q} + SZ));

    assign bus.presentRequest = visible && in_x && in_y;
    assign bus.topLeftX       = x_q;
    assign bus.topLeftY       = y_q;
    assign bus.collected      = coll_q;
    assign bus.active         = (state_q != IDLE);
endmodule
